gray_ptr_ctrl: RTL and testbench
================================

Name: gray_ptr_ctrl

Overview:
- Parametrised pointer controller for the clock-domain-crossing FIFOs in the PCS datapath.
- Owns one local pointer: a modulo-2·DEPTH binary counter with a registered single-bit-change Gray encoding, including across the wrap for non-power-of-2 depths.
- Synchronises and decodes the peer domain's Gray pointer and produces occupancy, full/empty and error flags.
- One instance sits on each side of an async FIFO; SIDE selects write or read role.

Parameters:
- DEPTH, 6, FIFO entries; integer ≥2, need not be a power of 2.
- SIDE, 0, 0 = write side (full flag, level = local−remote), 1 = read side (empty flag, level = remote−local).
- SYNC_STAGES, 2, flop stages on rmt_gray; range 2..4.
- Derived: PW = clog2(2·DEPTH); OFF = (2^PW − 2·DEPTH)/2; LW = clog2(DEPTH+1).

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- inc  in  1  request to advance local pointer this cycle
- ptr_gray  out  PW  registered Gray code of local pointer; drives the peer domain
- ptr_bin  out  PW  local binary pointer, 0..2·DEPTH−1; low part addresses RAM
- rmt_gray  in  PW  peer's ptr_gray (asynchronous)
- rmt_bin  out  PW  decoded, synchronised peer pointer
- level  out  LW  occupancy, 0..DEPTH
- flag  out  1  SIDE 0: full (level==DEPTH); SIDE 1: empty (level==0)
- blocked  out  1  one-cycle pulse: inc asserted while flag was high
- code_err  out  1  sticky: synchronised rmt_gray decoded outside 0..2·DEPTH−1

Behaviour:
- Code map: code(b) = bin2gray(b+OFF) for b in 0..2·DEPTH−1. Adjacent codes, including code(2·DEPTH−1)→code(0), differ in exactly one bit. For power-of-2 depths OFF=0 (plain reflected Gray).
- Reset, applied on the clk edge with reset high:
  - ptr_bin=0, ptr_gray=code(0), rmt_bin=0, level=0, code_err=0, blocked=0.
  - All sync flops load code(0).
  - flag = 0 for SIDE 0 and 1 for SIDE 1.
  - Reset mid-operation discards all state in the same edge; inc is ignored while reset is high.
- Advance:
  - Condition: inc && !flag in cycle n.
  - Cycle n+1: ptr_bin = (ptr_bin+1) mod 2·DEPTH and ptr_gray = code(new value).
  - Both outputs come straight from flops: no combinational path from inc, and no glitches on ptr_gray.
- Blocked:
  - Condition: inc && flag in cycle n.
  - Pointer holds and blocked=1 in cycle n+1 only.
  - Back-to-back blocked incs give back-to-back pulses.
- Remote path:
  - rmt_gray passes through SYNC_STAGES flops.
  - The last stage is decoded as b = gray2bin(s) − OFF and registered into rmt_bin.
  - Total latency from a stable change to rmt_bin update is SYNC_STAGES+1 cycles.
  - Illegal code (gray2bin(s) < OFF or ≥ OFF+2·DEPTH): rmt_bin holds its previous value and code_err sets, clearing only on reset.
- Level:
  - Combinational from the ptr_bin and rmt_bin registers, computed mod 2·DEPTH:
    - SIDE 0: (ptr_bin − rmt_bin) mod 2·DEPTH
    - SIDE 1: (rmt_bin − ptr_bin) mod 2·DEPTH
  - Any result > DEPTH is impossible in legal operation; it is clamped to DEPTH and also sets code_err.
- flag is combinational from level. An inc in the same cycle as a peer update sees the pre-update (pessimistic) flag: no overflow or underflow, at most one stall cycle.
- Wrap: the pointer crosses 2·DEPTH−1→0 without any special event; level arithmetic is continuous across the wrap.

Decomposition:
- Package gray_ptr_pkg holds:
  - functions bin2gray, gray2bin, ptr_width(depth), gray_offset(depth)
  - SIDE constants SIDE_WR=0, SIDE_RD=1
- Sub-module sync_bus_ff (WIDTH, STAGES): plain multi-flop synchroniser with synchronous active-high reset to a parameter value. It is reused by other CDC blocks.

Test Plan:
- DEPTH=6, SIDE=0, rmt_gray held at code(0)=4'b0011; 6 incs → ptr_bin 1..6, level 6, flag=1; 7th inc → ptr_bin stays 6, blocked=1 for one cycle.
- DEPTH=6, SIDE=0: loop 12 advances with the peer tracking → ptr_gray sequence ends at 4'b1011, returns to 4'b0011, single-bit change on every step including the wrap (checked by assertion on all DEPTH in 2..17).
- DEPTH=6, SIDE=1: peer pointer walks 0→3 → rmt_bin reaches 3 exactly 3 cycles after the last rmt_gray change, level=3, flag=0; 3 incs → level 0, flag=1, 4th inc blocked.
- Drive illegal rmt_gray 4'b0000 (below OFF=2) → code_err=1 after 3 cycles, rmt_bin unchanged; remains set until reset.
- Reset asserted with ptr_bin=5, level=4 → next edge ptr_bin=0, ptr_gray=4'b0011, level=0, flags at reset values; inc during reset has no effect.
- DEPTH=8 (OFF=0): 16 incs with peer following → plain reflected Gray 0000..1000, full at level 8, no code_err.

Source files
------------

// File: rtl/gray_ptr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_ptr_pkg
//  Description : Shared helpers for Gray-coded CDC pointers: binary/Gray
//                conversion, pointer width and the offset that keeps the
//                code map single-bit-change across the wrap for depths that
//                are not a power of two.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_ptr_pkg;

    localparam int unsigned SIDE_WR = 0;
    localparam int unsigned SIDE_RD = 1;

    // Reflected binary Gray encoding.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse of bin2gray: each binary bit is the XOR of all Gray bits at or
    // above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pointer counts modulo 2*depth, so it needs one bit beyond the address.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(2 * depth);
    endfunction

    // Centering the 2*depth used codes inside the 2^PW Gray cycle makes the
    // first and last used codes mirror images, which differ in the MSB only.
    function automatic int unsigned gray_offset(input int unsigned depth);
        return ((32'd1 << ptr_width(depth)) - 2 * depth) / 2;
    endfunction

endpackage : gray_ptr_pkg
`default_nettype wire

// File: rtl/sync_bus_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bus_ff
//  Description : Plain multi-flop bus synchroniser with synchronous
//                active-high reset to a configurable value. Only safe for
//                buses whose source changes at most one bit at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_bus_ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          STAGES    = 2,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Each stage takes the previous one; the first samples the async input.
    always_comb begin
        stage_d[0] = i_d;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchroniser chain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_q = stage_q[STAGES-1];

endmodule : sync_bus_ff
`default_nettype wire

// File: rtl/gray_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_ptr_ctrl
//  Description : One side of an async-FIFO pointer pair. Owns a modulo
//                2*DEPTH local pointer with a registered Gray image, brings
//                the peer's Gray pointer across, decodes it and derives
//                occupancy, full/empty, blocked and sticky code-error flags.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_ptr_ctrl
    import gray_ptr_pkg::*;
#(
    parameter  int unsigned DEPTH       = 6,
    parameter  int unsigned SIDE        = SIDE_WR,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned PW          = ptr_width(DEPTH),
    localparam int unsigned LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [PW-1:0] ptr_gray,
    output logic [PW-1:0] ptr_bin,
    input  logic [PW-1:0] rmt_gray,
    output logic [PW-1:0] rmt_bin,
    output logic [LW-1:0] level,
    output logic          flag,
    output logic          blocked,
    output logic          code_err
);

    localparam int unsigned   C_OFF       = gray_offset(DEPTH);
    localparam logic [PW-1:0] C_PTR_LAST  = PW'(2 * DEPTH - 1);
    localparam logic [PW:0]   C_TWO_D     = (PW+1)'(2 * DEPTH);
    localparam logic [PW:0]   C_DEPTH_W   = (PW+1)'(DEPTH);
    localparam logic [LW-1:0] C_LVL_FULL  = LW'(DEPTH);
    localparam logic [PW-1:0] C_GRAY_ZERO = PW'(bin2gray(C_OFF));

    // Code word for binary pointer value b.
    function automatic logic [PW-1:0] to_code(input logic [PW-1:0] b);
        return PW'(bin2gray(32'(b) + C_OFF));
    endfunction

    logic [PW-1:0] ptr_bin_q,  ptr_bin_d;
    logic [PW-1:0] ptr_gray_q, ptr_gray_d;
    logic [PW-1:0] rmt_bin_q,  rmt_bin_d;
    logic          blocked_q,  blocked_d;
    logic          code_err_q, code_err_d;

    logic [PW-1:0] w_sync_gray;
    logic [32:0]   w_rmt_unoff;
    logic          w_rmt_legal;
    logic [PW:0]   w_diff;
    logic [PW:0]   w_mod;
    logic          w_level_ovf;
    logic [LW-1:0] w_level;
    logic          w_flag;

    // Peer pointer crossing; reset value is the code of pointer zero.
    sync_bus_ff #(
        .WIDTH     (PW),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (C_GRAY_ZERO)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rmt_gray),
        .o_q   (w_sync_gray)
    );

    // Local pointer advance or stall; the Gray image is computed from the
    // next binary value so both registers update on the same edge.
    always_comb begin
        ptr_bin_d = ptr_bin_q;
        blocked_d = 1'b0;
        if (inc && w_flag) begin
            blocked_d = 1'b1;
        end else if (inc) begin
            ptr_bin_d = (ptr_bin_q == C_PTR_LAST) ? '0 : ptr_bin_q + 1'b1;
        end
        ptr_gray_d = to_code(ptr_bin_d);
    end

    // Decode the synchronised peer code; codes outside the used window keep
    // the old pointer and raise the sticky error.
    always_comb begin
        w_rmt_unoff = {1'b0, gray2bin(32'(w_sync_gray))} - {1'b0, C_OFF};
        w_rmt_legal = !w_rmt_unoff[32] && (w_rmt_unoff[31:0] < 32'(2 * DEPTH));
        rmt_bin_d   = w_rmt_legal ? PW'(w_rmt_unoff[31:0]) : rmt_bin_q;
        code_err_d  = code_err_q | ~w_rmt_legal | w_level_ovf;
    end

    // Occupancy modulo 2*DEPTH, clamped to DEPTH; flag reflects the role.
    always_comb begin
        if (SIDE == SIDE_WR) begin
            w_diff = {1'b0, ptr_bin_q} + C_TWO_D - {1'b0, rmt_bin_q};
        end else begin
            w_diff = {1'b0, rmt_bin_q} + C_TWO_D - {1'b0, ptr_bin_q};
        end
        w_mod       = (w_diff >= C_TWO_D) ? (w_diff - C_TWO_D) : w_diff;
        w_level_ovf = (w_mod > C_DEPTH_W);
        w_level     = w_level_ovf ? C_LVL_FULL : LW'(w_mod);
        if (SIDE == SIDE_WR) begin
            w_flag = (w_level == C_LVL_FULL);
        end else begin
            w_flag = (w_level == '0);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= C_GRAY_ZERO;
            rmt_bin_q  <= '0;
            blocked_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            rmt_bin_q  <= rmt_bin_d;
            blocked_q  <= blocked_d;
            code_err_q <= code_err_d;
        end
    end

    assign ptr_bin  = ptr_bin_q;
    assign ptr_gray = ptr_gray_q;
    assign rmt_bin  = rmt_bin_q;
    assign blocked  = blocked_q;
    assign code_err = code_err_q;
    assign level    = w_level;
    assign flag     = w_flag;

endmodule : gray_ptr_ctrl
`default_nettype wire

// File: tb/tb_gray_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_ptr_ctrl
//  Description : Scoreboard bench for gray_ptr_ctrl. Three instances:
//                unit 0 = DEPTH 6 write side, unit 1 = DEPTH 6 read side,
//                unit 2 = DEPTH 8 write side with 3 sync stages.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_ptr_ctrl;

    localparam int NU = 3;

    logic clk = 1'b0;
    logic rst;
    logic inc_w6, inc_r6, inc_w8;
    logic [3:0] rg_w6, rg_r6, rg_w8;
    logic [3:0] pg_w6, pg_r6, pg_w8;
    logic [3:0] pb_w6, pb_r6, pb_w8;
    logic [3:0] rb_w6, rb_r6, rb_w8;
    logic [2:0] lv_w6, lv_r6;
    logic [3:0] lv_w8;
    logic fl_w6, fl_r6, fl_w8, bk_w6, bk_r6, bk_w8, ce_w6, ce_r6, ce_w8;

    always #5 clk = ~clk;

    gray_ptr_ctrl #(.DEPTH(6), .SIDE(0), .SYNC_STAGES(2)) u_w6 (
        .clk(clk), .reset(rst), .inc(inc_w6), .ptr_gray(pg_w6), .ptr_bin(pb_w6),
        .rmt_gray(rg_w6), .rmt_bin(rb_w6), .level(lv_w6), .flag(fl_w6),
        .blocked(bk_w6), .code_err(ce_w6));
    gray_ptr_ctrl #(.DEPTH(6), .SIDE(1), .SYNC_STAGES(2)) u_r6 (
        .clk(clk), .reset(rst), .inc(inc_r6), .ptr_gray(pg_r6), .ptr_bin(pb_r6),
        .rmt_gray(rg_r6), .rmt_bin(rb_r6), .level(lv_r6), .flag(fl_r6),
        .blocked(bk_r6), .code_err(ce_r6));
    gray_ptr_ctrl #(.DEPTH(8), .SIDE(0), .SYNC_STAGES(3)) u_w8 (
        .clk(clk), .reset(rst), .inc(inc_w8), .ptr_gray(pg_w8), .ptr_bin(pb_w8),
        .rmt_gray(rg_w8), .rmt_bin(rb_w8), .level(lv_w8), .flag(fl_w8),
        .blocked(bk_w8), .code_err(ce_w8));

    // ---------------- reference model ----------------
    function automatic int dep_of(int u);  return (u == 2) ? 8 : 6; endfunction
    function automatic int side_of(int u); return (u == 1) ? 1 : 0; endfunction
    function automatic int stg_of(int u);  return (u == 2) ? 3 : 2; endfunction
    function automatic int off_of(int u);
        int span;
        span = 1;
        while (span < 2 * dep_of(u)) span = span * 2;
        return (span - 2 * dep_of(u)) / 2;
    endfunction
    function automatic int code_of(int u, int b);
        int v;
        v = b + off_of(u);
        return v ^ (v >> 1);
    endfunction
    // Table lookup of a code word; -1 when it is not in the map.
    function automatic int decode(int u, int g);
        for (int b = 0; b < 2 * dep_of(u); b++)
            if (code_of(u, b) == g) return b;
        return -1;
    endfunction

    int m_loc[NU], m_rmt[NU], m_err[NU], m_blk[NU];
    int m_pipe[NU][4];
    int c_inc[NU], c_code[NU], rdrv[NU];
    int c_rst;

    function automatic int lvl_raw(int u);
        int d2, diff;
        d2   = 2 * dep_of(u);
        diff = side_of(u) ? (m_rmt[u] - m_loc[u]) : (m_loc[u] - m_rmt[u]);
        return ((diff % d2) + d2) % d2;
    endfunction
    function automatic int lvl(int u);
        return (lvl_raw(u) > dep_of(u)) ? dep_of(u) : lvl_raw(u);
    endfunction
    function automatic int flg(int u);
        return side_of(u) ? int'(lvl(u) == 0) : int'(lvl(u) == dep_of(u));
    endfunction

    typedef struct {
        int u; int rs; int pb; int pg; int rb; int lv; int fl; int bk; int ce;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input int u, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_mis++;
            $display("FAIL u%0d %s @%0t: got %0d want %0d", u, nm, $time, got, want);
        end
    endtask

    // Apply one clock edge to the model of unit u and queue the result.
    task automatic model_edge(input int u);
        int raw, fl, s, dec;
        exp_t e;
        raw = lvl_raw(u);
        fl  = flg(u);
        s   = stg_of(u);
        if (c_rst != 0) begin
            m_loc[u] = 0; m_rmt[u] = 0; m_err[u] = 0; m_blk[u] = 0;
            for (int k = 0; k < 4; k++) m_pipe[u][k] = code_of(u, 0);
        end else begin
            m_blk[u] = (c_inc[u] != 0 && fl != 0) ? 1 : 0;
            if (c_inc[u] != 0 && fl == 0) m_loc[u] = (m_loc[u] + 1) % (2 * dep_of(u));
            dec = decode(u, m_pipe[u][s-1]);
            if (dec < 0) m_err[u] = 1; else m_rmt[u] = dec;
            if (raw > dep_of(u)) m_err[u] = 1;
            for (int k = 3; k > 0; k--) m_pipe[u][k] = m_pipe[u][k-1];
            m_pipe[u][0] = c_code[u];
        end
        e.u = u; e.rs = c_rst; e.pb = m_loc[u]; e.pg = code_of(u, m_loc[u]);
        e.rb = m_rmt[u]; e.lv = lvl(u); e.fl = flg(u); e.bk = m_blk[u]; e.ce = m_err[u];
        sbq.push_back(e);
    endtask

    task automatic drive();
        rst    = (c_rst != 0);
        inc_w6 = (c_inc[0] != 0);
        inc_r6 = (c_inc[1] != 0);
        inc_w8 = (c_inc[2] != 0);
        rg_w6  = 4'(c_code[0]);
        rg_r6  = 4'(c_code[1]);
        rg_w8  = 4'(c_code[2]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) model_edge(u);
    endtask

    task automatic cycle();
        drive();
        tick();
    endtask

    task automatic do_reset(input int n, input int incval);
        c_rst = 1;
        for (int u = 0; u < NU; u++) begin
            c_inc[u] = incval; rdrv[u] = 0; c_code[u] = code_of(u, 0);
        end
        repeat (n) cycle();
        c_rst = 0;
    endtask

    // Random traffic that keeps the peer pointer within legal distance.
    task automatic rand_cycle(input int bias);
        int d2, gap;
        for (int u = 0; u < NU; u++) begin
            d2 = 2 * dep_of(u);
            if (side_of(u) == 0) begin
                c_inc[u] = ($urandom_range(0, 3) < (bias ? 3 : 1)) ? 1 : 0;
                gap = ((m_loc[u] - rdrv[u]) % d2 + d2) % d2;
                if (gap > 0 && $urandom_range(0, 3) < (bias ? 1 : 3))
                    rdrv[u] = (rdrv[u] + 1) % d2;
            end else begin
                c_inc[u] = ($urandom_range(0, 3) < (bias ? 1 : 3)) ? 1 : 0;
                gap = ((rdrv[u] - m_loc[u]) % d2 + d2) % d2;
                if (gap < dep_of(u) && $urandom_range(0, 3) < (bias ? 3 : 1))
                    rdrv[u] = (rdrv[u] + 1) % d2;
            end
            c_code[u] = code_of(u, rdrv[u]);
        end
        cycle();
    endtask

    // ---------------- monitor ----------------
    int prev_pg[NU];
    always @(negedge clk) begin
        exp_t e;
        int a_pb, a_pg, a_rb, a_lv, a_fl, a_bk, a_ce;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.u)
                0: begin a_pb = int'(pb_w6); a_pg = int'(pg_w6); a_rb = int'(rb_w6); a_lv = int'(lv_w6);
                         a_fl = int'(fl_w6); a_bk = int'(bk_w6); a_ce = int'(ce_w6); end
                1: begin a_pb = int'(pb_r6); a_pg = int'(pg_r6); a_rb = int'(rb_r6); a_lv = int'(lv_r6);
                         a_fl = int'(fl_r6); a_bk = int'(bk_r6); a_ce = int'(ce_r6); end
                default: begin a_pb = int'(pb_w8); a_pg = int'(pg_w8); a_rb = int'(rb_w8); a_lv = int'(lv_w8);
                         a_fl = int'(fl_w8); a_bk = int'(bk_w8); a_ce = int'(ce_w8); end
            endcase
            chk("ptr_bin",  e.u, a_pb, e.pb);
            chk("ptr_gray", e.u, a_pg, e.pg);
            chk("rmt_bin",  e.u, a_rb, e.rb);
            chk("level",    e.u, a_lv, e.lv);
            chk("flag",     e.u, a_fl, e.fl);
            chk("blocked",  e.u, a_bk, e.bk);
            chk("code_err", e.u, a_ce, e.ce);
            if (e.rs == 0 && a_pg != prev_pg[e.u])
                chk("gray_1bit", e.u, $countones(4'(a_pg ^ prev_pg[e.u])), 1);
            prev_pg[e.u] = a_pg;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int saved_rb;
        c_rst = 1;
        for (int u = 0; u < NU; u++) begin
            c_inc[u] = 0; rdrv[u] = 0; c_code[u] = code_of(u, 0); prev_pg[u] = 0;
            m_loc[u] = 0; m_rmt[u] = 0; m_err[u] = 0; m_blk[u] = 0;
            for (int k = 0; k < 4; k++) m_pipe[u][k] = 0;
        end

        // Reset with inc high: inc must be ignored.
        do_reset(2, 1);

        // Fill w6 against a stationary reader; walk r6's peer 0->3 then drain.
        for (int t = 0; t < 14; t++) begin
            c_inc[0] = (t < 7) ? 1 : 0;
            c_code[0] = code_of(0, 0);
            if (t < 3) rdrv[1] = t + 1;
            c_code[1] = code_of(1, rdrv[1]);
            c_inc[1] = (t >= 6 && t <= 9) ? 1 : 0;
            c_inc[2] = 0;
            c_code[2] = code_of(2, 0);
            cycle();
            if (t == 6) chk("w6_blk_pulse", 0, int'(bk_w6), 1);
            if (t == 7) chk("w6_blk_end", 0, int'(bk_w6), 0);
        end
        chk("w6_full_ptr", 0, int'(pb_w6), 6);
        chk("w6_full_lvl", 0, int'(lv_w6), 6);
        chk("w6_full_flag", 0, int'(fl_w6), 1);
        chk("r6_rmt_bin", 1, int'(rb_r6), 3);
        chk("r6_empty_lvl", 1, int'(lv_r6), 0);
        chk("r6_empty_flag", 1, int'(fl_r6), 1);

        for (int n = 0; n < 2000; n++) rand_cycle((n / 150) % 2);

        // Mid-operation reset with incs asserted.
        do_reset(1, 1);
        chk("rst_ptr_bin", 0, int'(pb_w6), 0);
        chk("rst_ptr_gray", 0, int'(pg_w6), 3);
        chk("rst_flag_wr", 0, int'(fl_w6), 0);
        chk("rst_flag_rd", 1, int'(fl_r6), 1);

        for (int n = 0; n < 600; n++) rand_cycle((n / 100) % 2);

        // Illegal code on r6; reader-ahead-of-writer overflow on w8.
        saved_rb = m_rmt[1];
        c_code[1] = 0;
        rdrv[2] = (m_loc[2] + 1) % 16;
        c_code[2] = code_of(2, rdrv[2]);
        for (int u = 0; u < NU; u++) c_inc[u] = 0;
        for (int t = 0; t < 6; t++) begin
            cycle();
            if (t == 1) chk("r6_err_early", 1, int'(ce_r6), 0);
            if (t == 2) chk("r6_err_set", 1, int'(ce_r6), 1);
            if (t == 2) chk("r6_rb_hold", 1, int'(rb_r6), saved_rb);
        end
        chk("w8_ovf_err", 2, int'(ce_w8), 1);
        chk("w8_ovf_lvl", 2, int'(lv_w8), 8);
        c_code[1] = code_of(1, rdrv[1]);
        repeat (4) cycle();
        chk("r6_err_sticky", 1, int'(ce_r6), 1);

        do_reset(2, 1);
        chk("final_err_r6", 1, int'(ce_r6), 0);
        chk("final_err_w8", 2, int'(ce_w8), 0);
        repeat (2) cycle();

        @(negedge clk);
        #1;
        chk("sb_drain", 0, sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_gray_ptr_ctrl
`default_nettype wire
